// File: rtl/hs_burst_arbiter_pkg.sv
// Shared definitions for hs_burst_arbiter.
//   - State encodings for the burst-lock FSM (IDLE / HOLD / WAIT).
//   - id_w(n): requester-index width, never below 1 bit.
package hs_burst_arbiter_pkg;

  // IDLE: nothing held. HOLD: beat presented downstream.
  // WAIT: grant locked mid-burst, waiting for the owner's next beat.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_burst_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req     : request vector
//   ptr     : highest-priority index; the scan runs upward from it and wraps
//   gnt_idx : first set request at or after ptr (0 when none)
//   any     : at least one request set
module hs_burst_arbiter_rr_pick
  import hs_burst_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  int k;

  // Scan from the farthest offset down to offset 0, so the request
  // closest to ptr is the last to overwrite gnt_idx.
  always_comb begin
    gnt_idx = '0;
    k       = 0;
    any     = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N_REQ;
      if (req[k]) gnt_idx = ID_W'(k);
    end
  end

endmodule

// File: rtl/hs_burst_arbiter.sv
// Round-robin burst arbiter: N_REQ valid/ready requesters share one
// registered downstream channel. A grant stays locked to one requester
// until that requester's last beat is accepted downstream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/last/data   per-requester beat (data packed, DATA_W per slot)
//   req_ready             one-hot pop strobe to the granted requester
//   out_valid/last/data/id  registered downstream beat and source index
//   out_ready             downstream accept
//   busy                  FSM not idle
//   wdog_err              sticky stall watchdog flag
//
// Optional: define HS_BURST_ARBITER_WDOG_EN to enable the stall watchdog
// (WDOG_CYC stall cycles). Without it wdog_err stays 0.
module hs_burst_arbiter
  import hs_burst_arbiter_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int DATA_W   = 32,
  parameter  int WDOG_CYC = 16,
  localparam int ID_W     = id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    wdog_err
);

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            pop;
  logic [ID_W-1:0] pop_idx;
  logic [ID_W-1:0] gnt_next;

  hs_burst_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign gnt_next = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;

  // Pop decision. In HOLD the next beat of the burst is pulled in the same
  // cycle the current one is accepted. rst_n gates the strobe so that
  // req_ready is 0 while reset is held.
  always_comb begin
    pop     = 1'b0;
    pop_idx = gnt;
    case (state)
      IDLE: if (pick_any) begin
        pop     = 1'b1;
        pop_idx = pick_idx;
      end
      HOLD:    pop = out_ready && !out_last && req_valid[gnt];
      WAIT:    pop = req_valid[gnt];
      default: pop = 1'b0;
    endcase
    pop = pop && rst_n;
  end

  always_comb begin
    req_ready = '0;
    if (pop) req_ready[pop_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      out_last <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
    end else begin
      if (pop) begin
        out_data <= req_data[int'(pop_idx)*DATA_W +: DATA_W];
        out_last <= req_last[pop_idx];
        out_id   <= pop_idx;
        gnt      <= pop_idx;
      end
      case (state)
        IDLE: if (pop) state <= HOLD;
        HOLD: if (out_ready) begin
          if (out_last) begin
            state  <= IDLE;
            rr_ptr <= gnt_next;
          end else if (!pop) begin
            state  <= WAIT;
          end
        end
        WAIT:    if (pop) state <= HOLD;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

`ifdef HS_BURST_ARBITER_WDOG_EN
  localparam int WC_W = $clog2(WDOG_CYC + 1);

  logic [WC_W-1:0] stall_cnt;
  logic            stall;
  logic            wd_flag;

  assign stall = ((state == HOLD) && !out_ready) ||
                 ((state == WAIT) && !req_valid[gnt]);

  // Counter saturates at WDOG_CYC; the flag is set on the edge where the
  // count reaches WDOG_CYC and then holds until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      wd_flag   <= 1'b0;
    end else begin
      if (pop || ((state == HOLD) && out_ready))
        stall_cnt <= '0;
      else if (stall && (stall_cnt != WC_W'(WDOG_CYC)))
        stall_cnt <= stall_cnt + 1'b1;
      if (stall && (stall_cnt == WC_W'(WDOG_CYC - 1)))
        wd_flag <= 1'b1;
    end
  end

  assign wdog_err = wd_flag;
`else
  // Watchdog absent: constant-false compare keeps WDOG_CYC referenced.
  assign wdog_err = (WDOG_CYC < 0);
`endif

endmodule

// File: doc/hs_burst_arbiter.md
Name: hs_burst_arbiter

Overview:
- Round-robin arbiter sharing one downstream valid/ready channel among N_REQ requesters.
- Each requester sends bursts terminated by a `last` beat. The grant locks to one requester until its `last` beat is accepted downstream.
- Output stage is registered. `out_valid` and the payload hold stable from assertion up to and including the cycle `out_ready` is high, i.e. `out_valid s_until_with out_ready`.
- Sits in front of any single-ported sink that needs strict valid/ready handshakes.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 32, payload width.
- WDOG_CYC, 16, stall cycles before watchdog error (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester last-beat flag, qualified by req_valid.
- req_data  in  N_REQ*DATA_W  packed payloads; requester i occupies [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot pop strobe to the granted requester.
- out_valid  out  1  downstream beat valid.
- out_last  out  1  downstream last flag.
- out_data  out  DATA_W  downstream payload.
- out_id  out  ID_W=$clog2(N_REQ)  index of the source requester.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever state != IDLE.
- wdog_err  out  1  sticky watchdog error.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; rr_ptr=0; all outputs 0.
  - Reset mid-burst drops the held beat; no handshake completes.
- States:
  - IDLE: out_valid=0.
    - If any req_valid: pick the first set bit scanning from rr_ptr upward, wrapping modulo N_REQ. Drive req_ready[gnt]=1 that cycle. Capture data, last and id into the output register. Next state HOLD.
    - Otherwise stay in IDLE.
  - HOLD: out_valid=1; registered outputs frozen while out_ready=0. On out_ready=1:
    - out_last=1: rr_ptr<=(gnt+1)%N_REQ; next state IDLE, which adds one bubble cycle between bursts.
    - out_last=0 and req_valid[gnt]=1: pop the next beat in the same cycle (req_ready[gnt]=1) and stay in HOLD, giving 1 beat/cycle within a burst.
    - out_last=0 and req_valid[gnt]=0: next state WAIT, grant stays locked.
  - WAIT: out_valid=0; other requesters are ignored. When req_valid[gnt]=1: pop it, next state HOLD.
- req_ready is never asserted to a non-granted requester, and never while out_valid=1 && out_ready=0.
- Latency: beat popped at cycle t appears on out_* at t+1.
- Simultaneous requests are resolved purely by rr_ptr. A requester asserting req_valid while another burst is locked waits; no starvation beyond N_REQ-1 bursts.
- req_valid deasserting without a pop is tolerated and simply not granted. req_data of non-granted requesters is don't-care.

Optional Feature:
- Macro HS_BURST_ARBITER_WDOG_EN.
- Defined:
  - A stall counter increments each cycle in HOLD with out_ready=0, or in WAIT with req_valid[gnt]=0.
  - The counter clears on any completed handshake or pop.
  - When it reaches WDOG_CYC, wdog_err<=1. The flag is sticky until rst_n.
  - Arbitration is unaffected.
- Undefined: wdog_err tied 0; no counter logic.

Decomposition:
- Package hs_burst_arbiter_pkg:
  - state enum {IDLE, HOLD, WAIT};
  - id_w(n) function returning $clog2 with minimum 1.
- One sub-module: rr_pick, a combinational round-robin priority picker. Inputs req[N_REQ] and ptr; outputs gnt_idx and any.

Test Plan:
- Single requester 2, 3-beat burst D0..D2, out_ready=1 → out_valid high 3 consecutive cycles starting 1 cycle after first pop; out_id=2; out_last only on D2; busy falls the cycle after.
- All 4 requesters valid continuously with 1-beat bursts, rr_ptr=0 → grant order 0,1,2,3,0; one IDLE bubble between beats.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_valid/out_data/out_id unchanged all 5 cycles; no req_ready pulses; beat accepted on first cycle out_ready=1.
- Requester 1 drops req_valid mid-burst (2 cycles) while requester 0 is valid → state WAIT, requester 0 never granted until requester 1's last beat is accepted.
- rst_n pulled low in HOLD → all outputs 0 immediately (asynchronous); after release the first grant goes to requester 0.
- WDOG_EN with WDOG_CYC=16: hold out_ready=0 for 16 cycles → wdog_err=1 at cycle 16 and stays 1 after traffic resumes; macro undefined → wdog_err stays 0.
